// File: rtl/frame_buf_ctrl_if.sv
// Bus between frame_buf_ctrl and its producers/scanout driver.
// The master side drives requests and data. The slave side (the controller) returns status and colour.
interface frame_buf_ctrl_if #(
  parameter int PIX_W = 4
);
  // Scanout path
  logic [7:0]       x;
  logic [6:0]       y;
  logic             next_pixel;
  logic [15:0]      color;

  // Write path
  logic             wr_valid;
  logic             wr_ready;
  logic [7:0]       wr_x;
  logic [6:0]       wr_y;
  logic [PIX_W-1:0] wr_pix;

  // Clear and swap control
  logic             clear_req;
  logic [PIX_W-1:0] clear_pix;
  logic             swap_req;

  // Status
  logic             swap_pending;
  logic             swap_done;
  logic             front_sel;
  logic             busy;
  logic             err_oob;

  // Palette write port
  logic             pal_we;
  logic [PIX_W-1:0] pal_idx;
  logic [15:0]      pal_rgb;

  modport master (
    output x, y, next_pixel, wr_valid, wr_x, wr_y, wr_pix,
           clear_req, clear_pix, swap_req, pal_we, pal_idx, pal_rgb,
    input  color, wr_ready, swap_pending, swap_done, front_sel, busy, err_oob
  );

  modport slave (
    input  x, y, next_pixel, wr_valid, wr_x, wr_y, wr_pix,
           clear_req, clear_pix, swap_req, pal_we, pal_idx, pal_rgb,
    output color, wr_ready, swap_pending, swap_done, front_sel, busy, err_oob
  );
endinterface

// File: rtl/frame_buf_ctrl.sv
// Double-buffered frame-buffer controller.
// Writers fill the back bank while the front bank is scanned out. The banks swap only at the frame boundary.
module frame_buf_ctrl #(
  parameter int X_MAX  = 160,
  parameter int Y_MAX  = 80,
  parameter int PIX_W  = 4,
  parameter int PAL_EN = 0
) (
  input logic              clk,
  input logic              rst,
  frame_buf_ctrl_if.slave  bus
);
  localparam int DEPTH  = X_MAX * Y_MAX;
  localparam int ADDR_W = $clog2(DEPTH);

  typedef logic [ADDR_W-1:0] addr_t;
  typedef enum logic {IDLE, CLEAR} state_t;

  state_t           state;
  addr_t            cnt;
  logic [PIX_W-1:0] clr_pix_q;

  logic [PIX_W-1:0] bank0 [DEPTH];
  logic [PIX_W-1:0] bank1 [DEPTH];
  logic [PIX_W-1:0] rd0, rd1, pix;
  logic             rd_sel;

  addr_t            rd_addr, wr_addr, back_addr, addr0, addr1;
  logic             in_range, wr_acc, back_we, we0, we1;
  logic [PIX_W-1:0] back_data;
  logic             boundary, take;
  logic [15:0]      color_nx;

  always_comb begin
    rd_addr   = addr_t'(32'(bus.y) * X_MAX + 32'(bus.x));
    wr_addr   = addr_t'(32'(bus.wr_y) * X_MAX + 32'(bus.wr_x));
    in_range  = (32'(bus.wr_x) < X_MAX) && (32'(bus.wr_y) < Y_MAX);
    wr_acc    = bus.wr_valid & bus.wr_ready;
    back_we   = !rst && ((state == CLEAR) || (wr_acc && in_range));
    back_addr = (state == CLEAR) ? cnt : wr_addr;
    back_data = (state == CLEAR) ? clr_pix_q : bus.wr_pix;
    // Each bank has a single port: the front bank takes the scanout address and the back bank takes the write/clear address.
    addr0     = bus.front_sel ? back_addr : rd_addr;
    addr1     = bus.front_sel ? rd_addr : back_addr;
    we0       = back_we & bus.front_sel;
    we1       = back_we & ~bus.front_sel;
    boundary  = bus.next_pixel && (bus.x == 8'(X_MAX - 1)) && (bus.y == 7'(Y_MAX - 1));
    take      = bus.swap_pending && boundary && (state == IDLE);
    pix       = rd_sel ? rd1 : rd0;
  end

  always_ff @(posedge clk) begin
    if (we0) bank0[addr0] <= back_data;
    rd0 <= bank0[addr0];
  end

  always_ff @(posedge clk) begin
    if (we1) bank1[addr1] <= back_data;
    rd1 <= bank1[addr1];
  end

  // rd_sel records which bank the registered read data came from, so data read just before a swap is still selected correctly.
  always_ff @(posedge clk) begin
    rd_sel <= bus.front_sel;
  end

  generate
    if (PAL_EN != 0) begin : g_pal
      logic [15:0] pal [2**PIX_W];

      always_ff @(posedge clk) begin
        if (bus.pal_we) pal[bus.pal_idx] <= bus.pal_rgb;
      end

      assign color_nx = pal[pix];
    end else begin : g_gray
      logic [5:0] g;
      logic       unused_pal;

      // g takes the top six bits of the pixel value repeated end to end.
      always_comb begin
        g = '0;
        for (int unsigned i = 0; i < 6; i++) begin
          g[5-i] = pix[PIX_W - 1 - (i % PIX_W)];
        end
      end

      assign color_nx   = {g[5:1], g, g[5:1]};
      assign unused_pal = ^{bus.pal_we, bus.pal_idx, bus.pal_rgb};
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      state            <= IDLE;
      cnt              <= '0;
      clr_pix_q        <= '0;
      bus.wr_ready     <= 1'b1;
      bus.busy         <= 1'b0;
      bus.err_oob      <= 1'b0;
      bus.swap_pending <= 1'b0;
      bus.swap_done    <= 1'b0;
      bus.front_sel    <= 1'b0;
      bus.color        <= '0;
    end else begin
      bus.swap_done    <= take;
      bus.swap_pending <= (bus.swap_pending | bus.swap_req) & ~take;
      if (take)              bus.front_sel <= ~bus.front_sel;
      if (wr_acc && !in_range) bus.err_oob <= 1'b1;
      if (bus.next_pixel)    bus.color     <= color_nx;

      case (state)
        IDLE: begin
          if (bus.clear_req) begin
            state        <= CLEAR;
            cnt          <= '0;
            clr_pix_q    <= bus.clear_pix;
            bus.wr_ready <= 1'b0;
            bus.busy     <= 1'b1;
          end
        end
        CLEAR: begin
          if (cnt == addr_t'(DEPTH - 1)) begin
            state        <= IDLE;
            bus.wr_ready <= 1'b1;
            bus.busy     <= 1'b0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
      endcase
    end
  end
endmodule

// File: tb/tb_frame_buf_ctrl.sv
// Directed bench for frame_buf_ctrl. It runs one grayscale instance and one palette instance, both 160x80 with PIX_W=4.
module tb_frame_buf_ctrl;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  frame_buf_ctrl_if #(.PIX_W(4)) gi ();
  frame_buf_ctrl_if #(.PIX_W(4)) pi ();

  frame_buf_ctrl #(.X_MAX(160), .Y_MAX(80), .PIX_W(4), .PAL_EN(0)) u_gray (
    .clk(clk), .rst(rst), .bus(gi.slave)
  );

  frame_buf_ctrl #(.X_MAX(160), .Y_MAX(80), .PIX_W(4), .PAL_EN(1)) u_pal (
    .clk(clk), .rst(rst), .bus(pi.slave)
  );

  int checks   = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic scan_g(input logic [7:0] xx, input logic [6:0] yy, output logic [15:0] c);
    gi.x = xx; gi.y = yy;
    tick(); tick();
    gi.next_pixel = 1'b1;
    tick();
    gi.next_pixel = 1'b0;
    c = gi.color;
  endtask

  task automatic scan_p(input logic [7:0] xx, input logic [6:0] yy, output logic [15:0] c);
    pi.x = xx; pi.y = yy;
    tick(); tick();
    pi.next_pixel = 1'b1;
    tick();
    pi.next_pixel = 1'b0;
    c = pi.color;
  endtask

  task automatic wr_g(input logic [7:0] xx, input logic [6:0] yy, input logic [3:0] p);
    gi.wr_x = xx; gi.wr_y = yy; gi.wr_pix = p; gi.wr_valid = 1'b1;
    check("wr_hs_g", gi.wr_ready, 1);
    tick();
    gi.wr_valid = 1'b0;
  endtask

  task automatic wr_p(input logic [7:0] xx, input logic [6:0] yy, input logic [3:0] p);
    pi.wr_x = xx; pi.wr_y = yy; pi.wr_pix = p; pi.wr_valid = 1'b1;
    check("wr_hs_p", pi.wr_ready, 1);
    tick();
    pi.wr_valid = 1'b0;
  endtask

  task automatic clear_g(input logic [3:0] p);
    int n;
    gi.clear_pix = p; gi.clear_req = 1'b1;
    tick();
    gi.clear_req = 1'b0;
    n = 0;
    while (gi.busy && n < 20000) begin
      tick();
      n++;
    end
    check("clear_end", gi.busy, 0);
  endtask

  task automatic swap_pulse_g();
    gi.swap_req = 1'b1;
    tick();
    gi.swap_req = 1'b0;
  endtask

  initial begin
    #3ms;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] c;
    int n, bad, done_seen;

    {gi.x, gi.y, gi.next_pixel, gi.wr_valid, gi.wr_x, gi.wr_y, gi.wr_pix} = '0;
    {gi.clear_req, gi.clear_pix, gi.swap_req, gi.pal_we, gi.pal_idx, gi.pal_rgb} = '0;
    {pi.x, pi.y, pi.next_pixel, pi.wr_valid, pi.wr_x, pi.wr_y, pi.wr_pix} = '0;
    {pi.clear_req, pi.clear_pix, pi.swap_req, pi.pal_we, pi.pal_idx, pi.pal_rgb} = '0;

    // Reset values
    rst = 1'b1;
    tick(); tick(); tick();
    check("rst_color", gi.color, 16'h0000);
    check("rst_front_sel", gi.front_sel, 0);
    check("rst_swap_pending", gi.swap_pending, 0);
    check("rst_swap_done", gi.swap_done, 0);
    check("rst_busy", gi.busy, 0);
    check("rst_err_oob", gi.err_oob, 0);
    check("rst_wr_ready", gi.wr_ready, 1);
    rst = 1'b0;
    tick();

    // Clear back bank 1 with 3. A swap whose frame boundary falls during the clear must be deferred.
    gi.clear_pix = 4'h3; gi.clear_req = 1'b1;
    tick();
    gi.clear_req = 1'b0;
    n = 0; bad = 0; done_seen = 0;
    while (gi.busy && n < 13000) begin
      n++;
      if (gi.wr_ready) bad++;
      if (gi.swap_done) done_seen++;
      if (n == 10) gi.swap_req = 1'b1;
      if (n == 11) begin gi.swap_req = 1'b0; gi.x = 8'd159; gi.y = 7'd79; end
      if (n == 14) gi.next_pixel = 1'b1;
      if (n == 15) gi.next_pixel = 1'b0;
      tick();
    end
    check("clr_busy_cycles", n, 12800);
    check("clr_wr_ready_low", bad, 0);
    check("clr_swap_deferred", done_seen, 0);
    check("clr_pending_kept", gi.swap_pending, 1);
    check("clr_front_kept", gi.front_sel, 0);
    check("clr_wr_ready_back", gi.wr_ready, 1);

    // The deferred swap is taken at the next frame boundary.
    scan_g(8'd159, 7'd79, c);
    check("swap1_done", gi.swap_done, 1);
    check("swap1_front", gi.front_sel, 1);
    check("swap1_pending", gi.swap_pending, 0);
    tick();
    check("swap1_done_pulse", gi.swap_done, 0);
    scan_g(8'd0, 7'd0, c);    check("clr3_px0", c, 16'h3186);
    scan_g(8'd77, 7'd40, c);  check("clr3_mid", c, 16'h3186);
    scan_g(8'd159, 7'd79, c); check("clr3_last", c, 16'h3186);
    check("noswap_done", gi.swap_done, 0);
    check("noswap_front", gi.front_sel, 1);

    // Fill the new back bank (0): clear to 0, two pixels, then two out-of-range writes.
    clear_g(4'h0);
    wr_g(8'd0, 7'd0, 4'hF);
    wr_g(8'd1, 7'd0, 4'h8);
    check("oob_before", gi.err_oob, 0);
    wr_g(8'd160, 7'd0, 4'hF);
    wr_g(8'd0, 7'd80, 4'hF);
    check("oob_sticky", gi.err_oob, 1);

    // Tear-free swap: pixels earlier in the frame still come from the old bank.
    swap_pulse_g();
    scan_g(8'd0, 7'd0, c);    check("tear_old_px0", c, 16'h3186);
    check("tear_pending", gi.swap_pending, 1);
    scan_g(8'd1, 7'd0, c);    check("tear_old_px1", c, 16'h3186);
    check("tear_no_done", gi.swap_done, 0);
    scan_g(8'd159, 7'd79, c); check("tear_old_last", c, 16'h3186);
    check("swap2_done", gi.swap_done, 1);
    check("swap2_front", gi.front_sel, 0);
    scan_g(8'd0, 7'd0, c);    check("gray_F", c, 16'hFFFF);
    scan_g(8'd1, 7'd0, c);    check("gray_8", c, 16'h8C51);
    scan_g(8'd0, 7'd1, c);    check("oob_no_wrap", c, 16'h0000);
    scan_g(8'd159, 7'd79, c); check("oob_last_clean", c, 16'h0000);
    check("oob_still", gi.err_oob, 1);

    // Reset 100 cycles into a clear, with front_sel=1 and a swap pending
    swap_pulse_g();
    scan_g(8'd159, 7'd79, c);
    check("swap3_front", gi.front_sel, 1);
    swap_pulse_g();
    check("pre_rst_pending", gi.swap_pending, 1);
    gi.clear_pix = 4'h5; gi.clear_req = 1'b1;
    tick();
    gi.clear_req = 1'b0;
    check("pre_rst_busy", gi.busy, 1);
    repeat (99) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rstclr_busy", gi.busy, 0);
    check("rstclr_wr_ready", gi.wr_ready, 1);
    check("rstclr_front", gi.front_sel, 0);
    check("rstclr_pending", gi.swap_pending, 0);
    check("rstclr_err_oob", gi.err_oob, 0);

    // Palette lookup
    pi.pal_we = 1'b1; pi.pal_idx = 4'd5; pi.pal_rgb = 16'hF800;
    tick();
    pi.pal_idx = 4'd0; pi.pal_rgb = 16'h001F;
    tick();
    pi.pal_we = 1'b0;
    wr_p(8'd2, 7'd3, 4'd5);
    wr_p(8'd4, 7'd3, 4'd0);
    pi.swap_req = 1'b1;
    tick();
    pi.swap_req = 1'b0;
    scan_p(8'd159, 7'd79, c);
    check("pal_swap_done", pi.swap_done, 1);
    check("pal_front", pi.front_sel, 1);
    scan_p(8'd2, 7'd3, c);    check("pal_idx5", c, 16'hF800);
    scan_p(8'd4, 7'd3, c);    check("pal_idx0", c, 16'h001F);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/frame_buf_ctrl.md
# frame_buf_ctrl

Double-buffered, parametrised frame-buffer controller sitting between pixel producers (UART command path, random/pattern updaters) and the `st7735` scanout driver. It holds two pixel banks of `X_MAX*Y_MAX` entries, `PIX_W` bits each. Writers fill the back bank while the driver continuously reads the front bank, so updates never tear. Bank swaps occur only at a frame boundary, and an optional palette maps stored indices to RGB565.

## Interface
- `X_MAX`, 160, panel width in pixels (≤256)
- `Y_MAX`, 80, panel height in pixels (≤128)
- `PIX_W`, 4, stored bits per pixel (1..8)
- `PAL_EN`, 0, 0 = grayscale expansion, 1 = palette lookup (2^PIX_W × 16-bit entries)
- `clk` in 1 system clock
- `rst` in 1 synchronous, active-high reset
- `x` in 8 scanout column from `st7735`
- `y` in 7 scanout row from `st7735`
- `next_pixel` in 1 driver has consumed `color`; load the next one
- `color` out 16 RGB565 to driver
- `wr_valid` in 1 pixel write request
- `wr_ready` out 1 write accepted when `wr_valid & wr_ready`
- `wr_x` in 8, `wr_y` in 7, `wr_pix` in PIX_W write coordinate and data (back bank)
- `clear_req` in 1 pulse: fill back bank with `clear_pix`
- `clear_pix` in PIX_W fill value, sampled on `clear_req`
- `swap_req` in 1 pulse: request bank swap at next frame boundary
- `swap_pending` out 1 swap requested, not yet taken
- `swap_done` out 1 one-cycle pulse when the swap is taken
- `front_sel` out 1 bank currently scanned out
- `busy` out 1 clear in progress
- `err_oob` out 1 sticky: an out-of-range write was dropped
- `pal_we` in 1, `pal_idx` in PIX_W, `pal_rgb` in 16 palette write port (PAL_EN=1 only)

## Operation
- Banks: two inferred single-port BRAMs, 1-cycle registered read. Front bank read address is `y*X_MAX + x` every cycle. Back bank address is taken from the write or clear path. Width is `log2(X_MAX*Y_MAX)`.
- FSM states: IDLE, CLEAR.
  - IDLE: `wr_ready`=1.
  - IDLE → CLEAR on `clear_req`. Latch `clear_pix` and set address counter = 0.
  - CLEAR: write `clear_pix` to back[cnt], one per cycle, with `wr_ready`=0 and `busy`=1.
  - CLEAR → IDLE after address `X_MAX*Y_MAX-1` is written.
  - `clear_req` during CLEAR is ignored.
- Write path: an accepted write to (`wr_x`,`wr_y`) within range stores `wr_pix` at `wr_y*X_MAX+wr_x` of the back bank. If out of range, the handshake still completes, the data is dropped, and `err_oob` is set until `rst`.
- Swap:
  - `swap_req` sets `swap_pending`. Repeated requests while pending merge into one.
  - The swap is taken in the cycle where `next_pixel`=1 with `x==X_MAX-1` and `y==Y_MAX-1`, and only if not in CLEAR.
  - On the swap cycle: `front_sel` toggles, `swap_pending` clears, and `swap_done` pulses.
  - A boundary that falls during CLEAR defers the swap to the next frame boundary.
- Same-cycle swap and write: the write lands in the pre-swap back bank, which becomes the front.
- Colour expansion, applied to the front-bank read data `p`:
  - PAL_EN=0: form `g` = upper 6 bits of `p` replicated to ≥6 bits. `color = {g[5:1], g, g[5:1]}`.
  - PAL_EN=1: `color = pal[p]`. The palette is written synchronously by `pal_we`, is not reset, and is undefined until written.

## Timing
- Reset values: `color`=0, `front_sel`=0, `swap_pending`=0, `swap_done`=0, `busy`=0, `err_oob`=0, `wr_ready`=1, FSM=IDLE. Bank contents are not cleared.
- `rst` mid-CLEAR aborts the fill, leaving partial contents. `rst` drops any pending swap.
- Scanout latency: BRAM data is valid 1 cycle after `x`,`y` change. `color` is registered on the `next_pixel` cycle from the current BRAM output. `x`,`y` must be stable ≥2 cycles before `next_pixel`; `st7735` holds them for a full SPI word.
- PAL_EN=1 adds no cycle, because the palette is an asynchronous-read LUT.
- Write latency: data is in the bank 1 cycle after acceptance.
- Clear takes exactly `X_MAX*Y_MAX` cycles. `busy` rises the cycle after `clear_req` and falls the cycle after the last write.

## Test plan
- Grayscale, PIX_W=4: write back(0,0)=4'hF and (1,0)=4'h8, `swap_req`, run one frame. Required: after `swap_done`, `color` for pixel 0 = 16'hFFFF and for pixel 1 = 16'h8C51; `front_sel`=1.
- Tear-free swap: issue `swap_req` mid-frame. Required: `swap_pending`=1 until the `next_pixel` at (159,79), where `swap_done` pulses once; all earlier pixels in that frame show old-bank data.
- Clear: `clear_req` with `clear_pix`=4'h3. Required: `busy` high for 12800 cycles and `wr_ready`=0 throughout. A `swap_req` whose frame boundary falls during the clear is deferred. Next frame shows 0x3 everywhere.
- Out of range: write (160,0), then (0,80). Required: both handshakes complete, `err_oob`=1, and no bank location changes.
- Palette, PAL_EN=1: `pal[5]`=16'hF800, write pixel index 5, swap. Required: `color`=16'hF800 at that pixel.
- Reset during CLEAR: assert `rst` at cycle 100 of the fill. Required: next cycle `busy`=0, `wr_ready`=1, `front_sel`=0, `swap_pending`=0.
